// File: rtl/mips_pipe_core_if.sv
// Memory bus between mips_pipe_core (master) and its instruction/data memories (slave).
`timescale 1ns/1ps
interface mips_pipe_core_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 6
);
    // No valid/ready back-pressure: imem_data and dmem_rdata answer combinationally in the
    // same cycle as their address; a store commits at the rising edge ending a dmem_we cycle.
    logic [PC_W-1:0]   imem_addr;
    logic [15:0]       imem_data;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_we;
    logic              dmem_re;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output imem_addr,
        input  imem_data,
        output dmem_addr,
        output dmem_wdata,
        output dmem_we,
        output dmem_re,
        input  dmem_rdata
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_we,
        input  dmem_re,
        output dmem_rdata
    );
endinterface

// File: rtl/mips_pipe_core.sv
// Parametrised 5-stage MIPS pipeline (IF/ID/EX/MEM/WB) with hazard detection and ID-stage BNE.
// Define MIPS_FWD_EN for forwarding; without it dependents stall until the producer is in WB.
`timescale 1ns/1ps
module mips_pipe_core #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    mips_pipe_core_if.master  bus,
    output logic              retire,
    output logic [15:0]       stall_cnt,
    output logic [DATA_W-1:0] dbg_r1,
    output logic [DATA_W-1:0] dbg_r2,
    output logic [DATA_W-1:0] dbg_r3
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LW   = 4'd6;
    localparam logic [3:0] OP_SW   = 4'd7;
    localparam logic [3:0] OP_BNE  = 4'd8;

    logic [PC_W-1:0]   pc_q, pc_d;
    logic              ifid_valid_q;
    logic [15:0]       ifid_instr_q;
    logic [PC_W-1:0]   ifid_pc_q;

    logic              idex_valid_q, idex_we_q, idex_load_q, idex_store_q, idex_imm_q;
    logic [3:0]        idex_op_q, idex_dst_q;
    logic [DATA_W-1:0] idex_a_q, idex_b_q, idex_simm_q;
`ifdef MIPS_FWD_EN
    logic [3:0]        idex_rs_q, idex_rt_q;
`endif

    logic              exmem_valid_q, exmem_we_q, exmem_load_q, exmem_store_q;
    logic [3:0]        exmem_dst_q;
    logic [DATA_W-1:0] exmem_alu_q, exmem_sdata_q;

    logic              memwb_valid_q, memwb_we_q;
    logic [3:0]        memwb_dst_q;
    logic [DATA_W-1:0] memwb_data_q;

    logic [DATA_W-1:0] rf_q [16];
    logic [15:0]       stall_cnt_q;

    // ---------------- ID decode ----------------
    logic [3:0]        id_op, id_rs, id_rt, id_rd, id_dst;
    logic signed [3:0] id_simm4;
    logic              id_use_rs, id_use_rt, id_we, id_load, id_store, id_branch, id_imm;
    logic [DATA_W-1:0] id_rs_val, id_rt_val, br_a, br_b;
    logic              ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic              id_stall, br_taken;
    logic [PC_W-1:0]   br_target;

    assign id_op    = ifid_instr_q[15:12];
    assign id_rs    = ifid_instr_q[11:8];
    assign id_rt    = ifid_instr_q[7:4];
    assign id_rd    = ifid_instr_q[3:0];
    assign id_simm4 = ifid_instr_q[3:0];

    always_comb begin
        id_use_rs = ifid_valid_q && (id_op <= OP_BNE);
        id_use_rt = ifid_valid_q && ((id_op <= OP_SLT) || (id_op == OP_SW) || (id_op == OP_BNE));
        id_dst    = ((id_op == OP_ADDI) || (id_op == OP_LW)) ? id_rt : id_rd;
        id_we     = ifid_valid_q && (id_op <= OP_LW) && (id_dst != 4'd0);
        id_load   = ifid_valid_q && (id_op == OP_LW);
        id_store  = ifid_valid_q && (id_op == OP_SW);
        id_branch = ifid_valid_q && (id_op == OP_BNE);
        id_imm    = (id_op == OP_ADDI) || (id_op == OP_LW) || (id_op == OP_SW);
    end

    // Register read with same-cycle WB bypass; R0 always reads zero.
    always_comb begin
        id_rs_val = rf_q[id_rs];
        id_rt_val = rf_q[id_rt];
        if (memwb_we_q && (memwb_dst_q == id_rs)) id_rs_val = memwb_data_q;
        if (memwb_we_q && (memwb_dst_q == id_rt)) id_rt_val = memwb_data_q;
        if (id_rs == 4'd0) id_rs_val = '0;
        if (id_rt == 4'd0) id_rt_val = '0;
    end

    // *_we_q already excludes R0, so a hit implies a real nonzero destination.
    assign ex_hit_rs  = id_use_rs && idex_we_q  && (idex_dst_q  == id_rs);
    assign ex_hit_rt  = id_use_rt && idex_we_q  && (idex_dst_q  == id_rt);
    assign mem_hit_rs = id_use_rs && exmem_we_q && (exmem_dst_q == id_rs);
    assign mem_hit_rt = id_use_rt && exmem_we_q && (exmem_dst_q == id_rt);

`ifdef MIPS_FWD_EN
    assign id_stall = (idex_load_q && (ex_hit_rs || ex_hit_rt)) ||
                      (id_branch && (ex_hit_rs || ex_hit_rt ||
                                     (exmem_load_q && (mem_hit_rs || mem_hit_rt))));
    assign br_a = (mem_hit_rs && !exmem_load_q) ? exmem_alu_q : id_rs_val;
    assign br_b = (mem_hit_rt && !exmem_load_q) ? exmem_alu_q : id_rt_val;
`else
    assign id_stall = ex_hit_rs || ex_hit_rt || mem_hit_rs || mem_hit_rt;
    assign br_a     = id_rs_val;
    assign br_b     = id_rt_val;
`endif

    assign br_taken  = id_branch && !id_stall && (br_a != br_b);
    assign br_target = ifid_pc_q + PC_W'(1) + PC_W'(id_simm4);

    always_comb begin
        pc_d = pc_q + PC_W'(1);
        if (id_stall)      pc_d = pc_q;
        else if (br_taken) pc_d = br_target;
    end

    // ---------------- EX ----------------
    logic [DATA_W-1:0] ex_a, ex_b, ex_bsel, ex_alu;

`ifdef MIPS_FWD_EN
    // EX/MEM is assigned last so it wins over the older MEM/WB result.
    always_comb begin
        ex_a = idex_a_q;
        ex_b = idex_b_q;
        if (memwb_we_q && (memwb_dst_q == idex_rs_q)) ex_a = memwb_data_q;
        if (memwb_we_q && (memwb_dst_q == idex_rt_q)) ex_b = memwb_data_q;
        if (exmem_we_q && !exmem_load_q && (exmem_dst_q == idex_rs_q)) ex_a = exmem_alu_q;
        if (exmem_we_q && !exmem_load_q && (exmem_dst_q == idex_rt_q)) ex_b = exmem_alu_q;
    end
`else
    assign ex_a = idex_a_q;
    assign ex_b = idex_b_q;
`endif

    assign ex_bsel = idex_imm_q ? idex_simm_q : ex_b;

    always_comb begin
        case (idex_op_q)
            OP_SUB:  ex_alu = ex_a - ex_bsel;
            OP_AND:  ex_alu = ex_a & ex_bsel;
            OP_OR:   ex_alu = ex_a | ex_bsel;
            OP_SLT:  ex_alu = ($signed(ex_a) < $signed(ex_bsel)) ? DATA_W'(1) : '0;
            default: ex_alu = ex_a + ex_bsel;
        endcase
    end

    // ---------------- state ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= '0;
            ifid_valid_q  <= 1'b0;
            ifid_instr_q  <= '0;
            ifid_pc_q     <= '0;
            idex_valid_q  <= 1'b0;
            idex_we_q     <= 1'b0;
            idex_load_q   <= 1'b0;
            idex_store_q  <= 1'b0;
            idex_imm_q    <= 1'b0;
            idex_op_q     <= '0;
            idex_dst_q    <= '0;
            idex_a_q      <= '0;
            idex_b_q      <= '0;
            idex_simm_q   <= '0;
`ifdef MIPS_FWD_EN
            idex_rs_q     <= '0;
            idex_rt_q     <= '0;
`endif
            exmem_valid_q <= 1'b0;
            exmem_we_q    <= 1'b0;
            exmem_load_q  <= 1'b0;
            exmem_store_q <= 1'b0;
            exmem_dst_q   <= '0;
            exmem_alu_q   <= '0;
            exmem_sdata_q <= '0;
            memwb_valid_q <= 1'b0;
            memwb_we_q    <= 1'b0;
            memwb_dst_q   <= '0;
            memwb_data_q  <= '0;
            stall_cnt_q   <= '0;
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else begin
            pc_q <= pc_d;

            if (!id_stall) begin
                ifid_valid_q <= !br_taken;
                ifid_instr_q <= bus.imem_data;
                ifid_pc_q    <= pc_q;
            end

            // A stalled ID instruction leaves a bubble behind it in EX.
            idex_valid_q <= ifid_valid_q && !id_stall;
            idex_we_q    <= id_we && !id_stall;
            idex_load_q  <= id_load && !id_stall;
            idex_store_q <= id_store && !id_stall;
            idex_imm_q   <= id_imm;
            idex_op_q    <= id_op;
            idex_dst_q   <= id_dst;
            idex_a_q     <= id_rs_val;
            idex_b_q     <= id_rt_val;
            idex_simm_q  <= DATA_W'(id_simm4);
`ifdef MIPS_FWD_EN
            idex_rs_q    <= id_rs;
            idex_rt_q    <= id_rt;
`endif

            exmem_valid_q <= idex_valid_q;
            exmem_we_q    <= idex_we_q;
            exmem_load_q  <= idex_load_q;
            exmem_store_q <= idex_store_q;
            exmem_dst_q   <= idex_dst_q;
            exmem_alu_q   <= ex_alu;
            exmem_sdata_q <= ex_b;

            memwb_valid_q <= exmem_valid_q;
            memwb_we_q    <= exmem_we_q;
            memwb_dst_q   <= exmem_dst_q;
            memwb_data_q  <= exmem_load_q ? bus.dmem_rdata : exmem_alu_q;

            if (memwb_we_q) rf_q[memwb_dst_q] <= memwb_data_q;

            if (id_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.imem_addr  = pc_q;
    assign bus.dmem_addr  = exmem_alu_q;
    assign bus.dmem_wdata = exmem_sdata_q;
    assign bus.dmem_we    = exmem_store_q;
    assign bus.dmem_re    = exmem_load_q;

    assign retire    = memwb_valid_q;
    assign stall_cnt = stall_cnt_q;
    assign dbg_r1    = rf_q[1];
    assign dbg_r2    = rf_q[2];
    assign dbg_r3    = rf_q[3];
endmodule

// File: doc/mips_pipe_core.md
Name: mips_pipe_core

Overview:
- Parametrised successor to the 16-bit 5-stage MIPS pipeline top: IF, ID, EX, MEM, WB.
- Datapath width and PC width are generic.
- Adds what the previous core lacks: async reset, hazard detection, operand forwarding, load-use stall, ID-stage branch with flush, R0 hardwired to zero.
- Instruction and data memories are external; a harness instantiates them beside this core.

Parameters:
- DATA_W, 16, register/ALU/data-memory word width (≥8)
- PC_W, 6, program counter width, in instruction-word units

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_addr  out  PC_W  fetch address, equals PC
- imem_data  in  16  instruction, combinational from imem_addr
- dmem_addr  out  DATA_W  MEM-stage address (ALU result)
- dmem_wdata  out  DATA_W  MEM-stage store data
- dmem_we  out  1  store strobe, written at clk edge
- dmem_re  out  1  load strobe
- dmem_rdata  in  DATA_W  load data, combinational same cycle
- retire  out  1  pulse: a non-bubble instruction is in WB this cycle
- stall_cnt  out  16  count of stall cycles, saturating at 0xFFFF
- dbg_r1, dbg_r2, dbg_r3  out  DATA_W  live contents of R1..R3

Behaviour:
- Encoding: op[15:12], rs[11:8], rt[7:4], rd[3:0]; simm = [3:0] sign-extended to DATA_W.
- Opcodes:
  - 0 ADD rd=rs+rt; 1 SUB rd=rs-rt; 2 AND; 3 OR
  - 4 SLT rd = (signed rs<rt) ? 1 : 0
  - 5 ADDI rt=rs+simm
  - 6 LW rt=M[rs+simm]; 7 SW M[rs+simm]=rt
  - 8 BNE if rs!=rt then PC = PC_ID+1+simm
  - 9..F NOP
- Arithmetic wraps mod 2^DATA_W. PC wraps mod 2^PC_W. Branch target is truncated to PC_W.
- Register file: 16 x DATA_W.
  - R0 reads 0; writes to R0 are ignored and never forwarded.
  - A WB write is visible to an ID read in the same cycle (internal bypass).
- Reset (async, rst_n=0):
  - PC=0; all pipeline registers become bubbles (all control bits 0); regfile cleared; stall_cnt=0.
  - Outputs: dmem_we=0, dmem_re=0, retire=0, dbg_r*=0.
  - Reset mid-operation discards all in-flight instructions; in-flight stores are not performed.
- Latency: one instruction enters per cycle absent hazards. First retire occurs in the 5th cycle after reset release, with imem_addr=0 fetched in cycle 1.
- EX forwarding, per operand, priority order:
  1. EX/MEM result, if writing a matching nonzero register and not a load
  2. MEM/WB result (ALU result or load data)
  3. Register file
- Load-use stall: an ID instruction reading the rt/rs of an EX-stage LW holds PC and IF/ID and inserts a bubble into EX. Duration is 1 cycle.
- Branch in ID: comparator operands come from the register file, or are forwarded from EX/MEM (non-load) or MEM/WB.
  - Producer in EX: stall 1 cycle.
  - LW in EX: stall 2 cycles. LW in MEM: stall 1 cycle.
- Taken BNE: PC loads target; IF/ID becomes a bubble (1-cycle penalty). Not-taken costs nothing.
- Simultaneous stall and taken branch cannot occur: the branch evaluates only when not stalled.
- Any stall cycle increments stall_cnt (saturating). Flush bubbles do not count.
- SW writes at the clk edge that ends its MEM cycle. dmem_wdata is the forwarded rt value.

Optional Feature:
- Macro MIPS_FWD_EN.
- Defined: forwarding exactly as above.
- Undefined:
  - No EX forwarding paths.
  - Any ID instruction whose source matches the nonzero destination of an instruction in EX or MEM stalls until that instruction reaches WB. Correctness then relies on the WB→ID regfile bypass only.
  - Results are identical to the forwarding build; only cycle counts and stall_cnt differ.

Test Plan:
- Reset, ADDI R1=R0+5, ADDI R2=R0-3, NOPs → dbg_r1=5, dbg_r2=0xFFFD, stall_cnt=0.
- Back-to-back dependents: ADDI R1=R0+7; ADD R2=R1+R1; SUB R3=R2-R1 → R2=14, R3=7, stall_cnt=0 (fwd) / 4 (no fwd).
- SW R1→M[R0+2], then LW R3=M[R0+2], then ADD R2=R3+R3 with R1=9 → R3=9, R2=18, exactly 1 stall, dmem_we high 1 cycle at addr 2.
- Loop: R1=3; ADDI R1=R1-1; BNE R1,R0,-2 → R1 ends 0, branch taken twice, PC falls through after 3rd BNE. Penalty 1 cycle/taken plus producer stall.
- Writes to R0 (ADDI R0=R0+4, then ADD R1=R0+R0) → R1=0.
- Assert rst_n low mid-loop with SW in EX → no dmem_we, PC=0 asynchronously, dbg_r*=0, program restarts cleanly.
